pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  - Next-generation main control for the 5-stage RV32I pipeline.
//  - Decodes the IF/ID opcode into a control bundle and registers it into the ID/EX control register.
//  - Adds load-use stall and taken-branch/jump flush sequencing, and decodes LUI/AUIPC.
//  - Drives pc_write / if_id_write / if_id_flush to the fetch stage.
// PARAMETERS
//  - FLUSH_DEPTH  2  bubbles inserted after an EX redirect (legal range >= 1)
//  - REG_AW       5  register-address width
// PORTS
//  - clk            in   1       rising-edge clock
//  - rst_n          in   1       asynchronous, active-low reset
//  - id_opcode      in   7       opcode field of the instruction held in IF/ID
//  - id_rs1         in   REG_AW  rs1 of the IF/ID instruction
//  - id_rs2         in   REG_AW  rs2 of the IF/ID instruction
//  - ex_mem_read    in   1       instruction currently in EX is a load
//  - ex_rd          in   REG_AW  rd of the instruction currently in EX
//  - ex_redirect    in   1       branch taken or jump resolved in EX this cycle
//  - ex_ctrl        out  ctrl_t  registered bundle: alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op[1:0], branch, jalr_sel, lui, auipc
//  - ex_valid       out  1       ex_ctrl holds a real instruction (0 = bubble)
//  - pc_write       out  1       PC may advance
//  - if_id_write    out  1       IF/ID may load
//  - if_id_flush    out  1       IF/ID is cleared to NOP next edge
//  - illegal        out  1       sticky illegal-opcode flag (feature-gated)
// BEHAVIOUR
//  - Reset (async, rst_n=0): ex_ctrl=0, ex_valid=0, state=RUN, counter=0, illegal=0.
//    - Comb outputs during reset: pc_write=1, if_id_write=1, if_id_flush=0.
//    - Reset mid-flush or mid-stall abandons the sequence immediately.
//  - Decode: combinational, same-cycle.
//    - ex_ctrl/ex_valid update one clk after the IF/ID opcode is presented (latency 1).
//  - Decode table:
//    - R-type: reg_write, alu_op=10.
//    - I-ALU: alu_src, reg_write, alu_op=10.
//    - Load: alu_src, mem_to_reg, mem_read, reg_write, alu_op=00.
//    - Store: alu_src, mem_write, alu_op=00.
//    - Branch: branch, alu_op=01.
//    - JAL: branch, jalr_sel, reg_write.
//    - JALR: jalr_sel, reg_write.
//    - LUI: lui, alu_src, reg_write.
//    - AUIPC: auipc, alu_src, reg_write.
//  - hazard = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || (ex_rd==id_rs2 && opcode uses rs2)).
//    - rs2 is used by R-type, store and branch only.
//  - FSM states: RUN, STALL, FLUSH.
//    - RUN: if ex_redirect -> FLUSH, counter=FLUSH_DEPTH-1; elif hazard -> STALL; else load decoded bundle, ex_valid=1.
//    - STALL (exactly 1 cycle): pc_write=0, if_id_write=0, bubble into ID/EX.
//      - Returns to RUN, unless ex_redirect is high, in which case -> FLUSH.
//    - FLUSH: if_id_flush=1 and bubble into ID/EX every cycle; counter decrements; counter==0 -> RUN.
//      - ex_redirect in FLUSH reloads counter=FLUSH_DEPTH-1.
//  - Priority: ex_redirect > hazard > normal decode.
//    - A hazard seen in FLUSH is ignored, because the flushed instruction is discarded.
//  - Bubble: ex_ctrl=0, ex_valid=0. A bubble never asserts reg_write or mem_write.
//  - Counter width: $clog2(FLUSH_DEPTH+1); no wrap, since it saturates at 0.
//  - Unknown opcode: all-zero bundle with ex_valid=1 (default build).
// CONFIGURATION
//  - Macro CTRL_ILLEGAL_TRAP_EN.
//  - Defined: an unknown opcode in RUN inserts a bubble (ex_valid=0) and sets illegal.
//    - illegal stays set until rst_n.
//    - An opcode discarded by FLUSH never sets it.
//  - Undefined: illegal tied 0; unknown opcode gives an all-zero bundle with ex_valid=1.
// STRUCTURE
//  - ctrl_pkg: opcode localparams (R_TYPE, I_TYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), ctrl_t packed struct, alu_op_e, ctrl_state_e {RUN, STALL, FLUSH}.
//  - Sub-module ctrl_decoder: combinational, opcode -> ctrl_t + known flag.
//  - pipe_ctrl_unit holds the FSM, counter, hazard compare and ID/EX register.
// TESTING
//  - Reset: rst_n=0 asynchronously mid-FLUSH -> ex_valid=0, ex_ctrl=0, pc_write=1 immediately; RUN after release.
//  - Decode sweep: each of the 9 opcodes in RUN -> next-cycle ex_ctrl matches the table.
//    - e.g. 7'b0000011 gives alu_src=1, mem_to_reg=1, mem_read=1, reg_write=1, alu_op=00.
//  - Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, R-type -> 1 cycle pc_write=0, if_id_write=0, bubble; then decoded.
//    - With ex_rd=0 -> no stall.
//    - id_rs2=5 on an I-type -> no stall.
//  - Flush: ex_redirect pulse with FLUSH_DEPTH=2 -> if_id_flush=1 for 2 cycles, 2 bubbles, then RUN.
//    - A second ex_redirect on flush cycle 2 -> 2 more flush cycles.
//  - Simultaneous: hazard and ex_redirect in the same cycle -> FLUSH entered, no STALL cycle.
//  - CTRL_ILLEGAL_TRAP_EN: opcode 7'b1111111 in RUN -> bubble, illegal=1 sticky.
//    - The same opcode during FLUSH -> illegal stays 0.
//    - Without the macro -> illegal=0, ex_valid=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and opcode constants for the RV32I pipeline main control.
package ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        alu_op_e alu_op;
        logic    branch;
        logic    jalr_sel;
        logic    lui;
        logic    auipc;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder: produces the control bundle and a known-opcode flag.
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output ctrl_t      ctrl,
    output logic       known
);

    always_comb begin
        ctrl  = '0;
        known = 1'b1;
        case (opcode)
            R_TYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            I_TYPE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            LOAD: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_BRANCH;
            end
            JAL: begin
                ctrl.branch    = 1'b1;
                ctrl.jalr_sel  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            JALR: begin
                ctrl.jalr_sel  = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            LUI: begin
                ctrl.lui       = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            AUIPC: begin
                ctrl.auipc     = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            default: known = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline main control: decode into ID/EX, load-use stall and redirect flush sequencing.
// Optional CTRL_ILLEGAL_TRAP_EN turns unknown opcodes into bubbles and sets a sticky flag.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_redirect,
    output ctrl_t             ex_ctrl,
    output logic              ex_valid,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              illegal
);

    localparam int unsigned CntW = $clog2(FLUSH_DEPTH + 1);
    localparam logic [CntW-1:0] CntReload = CntW'(FLUSH_DEPTH - 1);

    ctrl_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            valid_q, valid_d;
    ctrl_t           dec_ctrl;
    logic            dec_known;
    logic            uses_rs2;
    logic            hazard;

    ctrl_decoder u_decoder (
        .opcode (id_opcode),
        .ctrl   (dec_ctrl),
        .known  (dec_known)
    );

    assign uses_rs2 = (id_opcode == R_TYPE) || (id_opcode == STORE) || (id_opcode == BRANCH);
    assign hazard   = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && uses_rs2));

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctrl_d      = '0;
        valid_d     = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        unique case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    state_d = FLUSH;
                    cnt_d   = CntReload;
                end else if (hazard) begin
                    state_d = STALL;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    if (dec_known) begin
                        ctrl_d  = dec_ctrl;
                        valid_d = 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
`else
                    ctrl_d  = dec_ctrl;
                    valid_d = 1'b1;
`endif
                end
            end
            STALL: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if (ex_redirect) begin
                    state_d = FLUSH;
                    cnt_d   = CntReload;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // Hazards are ignored here: the instruction in IF/ID is being discarded.
                if_id_flush = 1'b1;
                if (ex_redirect) begin
                    cnt_d = CntReload;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    logic unused_known;
    assign unused_known = dec_known;
    assign illegal      = 1'b0;
`endif

    assign ex_ctrl  = ctrl_q;
    assign ex_valid = valid_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed self-checking bench for pipe_ctrl_unit (FLUSH_DEPTH=2, REG_AW=5).
module tb_pipe_ctrl_unit;
    import ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    ctrl_t      ex_ctrl;
    logic       ex_valid;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    // Bundle bit order: alu_src mem_to_reg reg_write mem_read mem_write alu_op[1:0]
    //                   branch jalr_sel lui auipc
    logic [6:0]  opc_tab [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [10:0] exp_tab [9] = '{11'b00100_10_0000, 11'b10100_10_0000, 11'b11110_00_0000,
                                 11'b10001_00_0000, 11'b00000_01_1000, 11'b00100_00_1100,
                                 11'b00100_00_0100, 11'b10100_00_0010, 11'b10100_00_0001};

    pipe_ctrl_unit #(
        .FLUSH_DEPTH (2),
        .REG_AW      (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_opcode   (id_opcode),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .ex_redirect (ex_redirect),
        .ex_ctrl     (ex_ctrl),
        .ex_valid    (ex_valid),
        .pc_write    (pc_write),
        .if_id_write (if_id_write),
        .if_id_flush (if_id_flush),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_opcode   = 7'b0010011;
        id_rs1      = 5'd1;
        id_rs2      = 5'd2;
        ex_mem_read = 1'b0;
        ex_rd       = 5'd0;
        ex_redirect = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        idle();
        rst_n = 1'b0;
        #3;
        got = ex_ctrl;
        checks++;
        if (got !== 11'd0 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: ctrl=%b valid=%b want ctrl=0 valid=0", got, ex_valid);
        end
        checks++;
        if ({pc_write, if_id_write, if_id_flush, illegal} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_comb: pc_w/ifid_w/flush/illegal=%b want 1100",
                     {pc_write, if_id_write, if_id_flush, illegal});
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: valid=%b want 0", ex_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [10:0] got;
        for (int i = 0; i < 9; i++) begin
            id_opcode = opc_tab[i];
            tick();
            got = ex_ctrl;
            checks++;
            if (got !== exp_tab[i] || ex_valid !== 1'b1) begin
                errors++;
                $display("FAIL decode[%b]: ctrl=%b valid=%b want ctrl=%b valid=1",
                         opc_tab[i], got, ex_valid, exp_tab[i]);
            end
        end
        idle();
    endtask

    task automatic test_load_use();
        logic [10:0] got;
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs1      = 5'd5;
        id_opcode   = 7'b0110011;
        tick();
        ex_mem_read = 1'b0;
        ex_rd       = 5'd0;
        checks++;
        if ({pc_write, if_id_write, ex_valid} !== 3'b000) begin
            errors++;
            $display("FAIL load_use_stall: pc_w/ifid_w/valid=%b want 000",
                     {pc_write, if_id_write, ex_valid});
        end
        tick();
        checks++;
        if ({pc_write, if_id_write, ex_valid} !== 3'b110) begin
            errors++;
            $display("FAIL load_use_release: pc_w/ifid_w/valid=%b want 110",
                     {pc_write, if_id_write, ex_valid});
        end
        tick();
        got = ex_ctrl;
        checks++;
        if (got !== 11'b00100_10_0000 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_use_decoded: ctrl=%b valid=%b want 00100100000 valid=1",
                     got, ex_valid);
        end
        // rd == x0 never stalls
        ex_mem_read = 1'b1;
        ex_rd       = 5'd0;
        id_rs1      = 5'd0;
        tick();
        checks++;
        if (pc_write !== 1'b1 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_use_x0: pc_w=%b valid=%b want 1 1", pc_write, ex_valid);
        end
        // rs2 match on I-type is not a dependency
        ex_rd     = 5'd5;
        id_rs1    = 5'd1;
        id_rs2    = 5'd5;
        id_opcode = 7'b0010011;
        tick();
        got = ex_ctrl;
        checks++;
        if (pc_write !== 1'b1 || ex_valid !== 1'b1 || got !== 11'b10100_10_0000) begin
            errors++;
            $display("FAIL load_use_itype_rs2: pc_w=%b valid=%b ctrl=%b want 1 1 10100100000",
                     pc_write, ex_valid, got);
        end
        // rs2 match on a store is a dependency
        id_opcode = 7'b0100011;
        tick();
        checks++;
        if (pc_write !== 1'b0 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_use_store_rs2: pc_w=%b valid=%b want 0 0", pc_write, ex_valid);
        end
        idle();
        tick();
        tick();
    endtask

    task automatic test_flush();
        logic [3:0] seq;
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        seq[3] = if_id_flush;
        tick();
        seq[2] = if_id_flush;
        checks++;
        if (ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble: valid=%b want 0", ex_valid);
        end
        tick();
        seq[1] = if_id_flush;
        tick();
        seq[0] = ex_valid;
        checks++;
        if (seq !== 4'b1101) begin
            errors++;
            $display("FAIL flush_seq: flush,flush,flush,valid=%b want 1101", seq);
        end
        // Second redirect on the last flush cycle extends the sequence
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        seq[3] = if_id_flush;
        tick();
        seq[2] = if_id_flush;
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        seq[1] = if_id_flush;
        tick();
        seq[0] = if_id_flush;
        checks++;
        if (seq !== 4'b1111) begin
            errors++;
            $display("FAIL flush_reload: flush x4=%b want 1111", seq);
        end
        tick();
        checks++;
        if (if_id_flush !== 1'b0 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL flush_exit: flush=%b pc_w=%b want 0 1", if_id_flush, pc_write);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs1      = 5'd5;
        id_opcode   = 7'b0110011;
        ex_redirect = 1'b1;
        tick();
        idle();
        checks++;
        if ({pc_write, if_id_write, if_id_flush} !== 3'b111) begin
            errors++;
            $display("FAIL simul_no_stall: pc_w/ifid_w/flush=%b want 111",
                     {pc_write, if_id_write, if_id_flush});
        end
        tick();
        tick();
        // Redirect arriving in the stall cycle goes straight to flush
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs1      = 5'd5;
        tick();
        idle();
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        checks++;
        if (if_id_flush !== 1'b1 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL stall_redirect: flush=%b pc_w=%b want 1 1", if_id_flush, pc_write);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [10:0] got;
        id_opcode = 7'b0000011;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        got = ex_ctrl;
        checks++;
        if (got !== 11'd0 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_valid: ctrl=%b valid=%b want 0 0", got, ex_valid);
        end
        #3;
        rst_n = 1'b1;
        idle();
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        got = ex_ctrl;
        checks++;
        if (got !== 11'd0 || ex_valid !== 1'b0 || pc_write !== 1'b1 || if_id_flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flush: ctrl=%b valid=%b pc_w=%b flush=%b want 0 0 1 0",
                     got, ex_valid, pc_write, if_id_flush);
        end
        #3;
        rst_n = 1'b1;
        tick();
        checks++;
        if (ex_valid !== 1'b1 || if_id_flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_run_after: valid=%b flush=%b want 1 0", ex_valid, if_id_flush);
        end
    endtask

    task automatic test_illegal();
        logic [10:0] got;
        do_reset();
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        id_opcode   = 7'b1111111;
        tick();
        tick();
        idle();
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_in_flush: illegal=%b want 0", illegal);
        end
        tick();
        id_opcode = 7'b1111111;
        tick();
        got = ex_ctrl;
`ifdef CTRL_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== 1'b1 || ex_valid !== 1'b0 || got !== 11'd0) begin
            errors++;
            $display("FAIL illegal_trap: illegal=%b valid=%b ctrl=%b want 1 0 0",
                     illegal, ex_valid, got);
        end
        idle();
        tick();
        tick();
        checks++;
        if (illegal !== 1'b1 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sticky: illegal=%b valid=%b want 1 1", illegal, ex_valid);
        end
`else
        checks++;
        if (illegal !== 1'b0 || ex_valid !== 1'b1 || got !== 11'd0) begin
            errors++;
            $display("FAIL illegal_default: illegal=%b valid=%b ctrl=%b want 0 1 0",
                     illegal, ex_valid, got);
        end
        idle();
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_decode();
        test_load_use();
        test_flush();
        test_simultaneous();
        test_reset_mid();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
